// File: rtl/cache_pkg.sv
// Shared widths, state encoding and block-address helpers for the cache miss handler.
package cache_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned WORD_BYTES  = 2;
    localparam int unsigned WORD_W      = 8 * WORD_BYTES;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned BLOCK_BYTES = BLOCK_WORDS * WORD_BYTES;
    localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES);
    localparam int unsigned CNT_W       = $clog2(BLOCK_WORDS) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_TAG  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WB   = ST_WB,
        S_FILL = ST_FILL,
        S_TAG  = ST_TAG
    } state_e;

    // Clear the byte-offset bits so the address points at the block base.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(BLOCK_BYTES - 1);
    endfunction

    function automatic logic [OFF_W-1:0] word_off(input logic [CNT_W-1:0] cnt);
        return OFF_W'(32'(cnt) * WORD_BYTES);
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base + ADDR_W'(32'(cnt) * WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_miss_handler_if.sv
// Signals between the miss handler, the tag/data arrays and the memory port.
interface cache_miss_handler_if;
    import cache_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_addr;
    logic                victim_dirty;
    logic [ADDR_W-1:0]   victim_addr;
    logic [WORD_W-1:0]   cache_rdata;
    logic                mem_ready;
    logic                mem_data_valid;
    logic [WORD_W-1:0]   mem_rdata;
    logic                fsm_busy;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                write_data_array;
    logic [WORD_W-1:0]   cache_wdata;
    logic [OFF_W-1:0]    cache_word_offset;
    logic                write_tag_array;
    logic [ADDR_W-1:0]   base_addr;

    modport master (
        input  miss_detected, miss_addr, victim_dirty, victim_addr, cache_rdata,
               mem_ready, mem_data_valid, mem_rdata,
        output fsm_busy, mem_read, mem_write, mem_addr, mem_wdata, write_data_array,
               cache_wdata, cache_word_offset, write_tag_array, base_addr
    );

    modport slave (
        output miss_detected, miss_addr, victim_dirty, victim_addr, cache_rdata,
               mem_ready, mem_data_valid, mem_rdata,
        input  fsm_busy, mem_read, mem_write, mem_addr, mem_wdata, write_data_array,
               cache_wdata, cache_word_offset, write_tag_array, base_addr
    );

endinterface

// File: rtl/block_word_counter.sv
// Word counter for one block transfer; last_o flags that the current count is the final word.
module block_word_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == CNT_W'(BLOCK_WORDS - 1));
        end
    end

    assign count_o = count_q;
    assign last_o  = last_q;

endmodule

// File: rtl/cache_miss_handler.sv
// Miss handler: optional dirty-victim write-back, pipelined block fill, then tag update.
module cache_miss_handler
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cache_miss_handler_if.master bus
);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q, victim_q, addr_q;
    logic [OFF_W-1:0]  off_q;
    logic              busy_q, rd_q, wr_q, tag_q;

    logic             wb_inc, iss_inc, rcv_inc, cnt_clr;
    logic [CNT_W-1:0] wb_cnt, iss_cnt, rcv_cnt;
    logic [CNT_W-1:0] wb_next, iss_next, rcv_next;
    logic             wb_last, iss_last, rcv_last;
    logic             rd_more;

    assign wb_inc  = (state_q == S_WB) && bus.mem_ready;
    assign iss_inc = (state_q == S_FILL) && rd_q && bus.mem_ready;
    assign rcv_inc = (state_q == S_FILL) && bus.mem_data_valid;
    assign cnt_clr = (state_q == S_TAG);

    // Counter values after this edge, so request outputs can be registered.
    assign wb_next  = wb_cnt + CNT_W'(wb_inc);
    assign iss_next = iss_cnt + CNT_W'(iss_inc);
    assign rcv_next = rcv_cnt + CNT_W'(rcv_inc);
    assign rd_more  = rd_q && !(iss_inc && iss_last);

    block_word_counter u_wb_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wb_inc),
        .clr_i   (cnt_clr),
        .count_o (wb_cnt),
        .last_o  (wb_last)
    );

    block_word_counter u_iss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (iss_inc),
        .clr_i   (cnt_clr),
        .count_o (iss_cnt),
        .last_o  (iss_last)
    );

    block_word_counter u_rcv_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (rcv_inc),
        .clr_i   (cnt_clr),
        .count_o (rcv_cnt),
        .last_o  (rcv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            victim_q <= '0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            off_q    <= '0;
            tag_q    <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            off_q  <= '0;
            tag_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.miss_detected) begin
                        base_q   <= block_base(bus.miss_addr);
                        victim_q <= block_base(bus.victim_addr);
                        busy_q   <= 1'b1;
                        if (bus.victim_dirty) begin
                            state_q <= S_WB;
                            wr_q    <= 1'b1;
                            addr_q  <= block_base(bus.victim_addr);
                        end else begin
                            state_q <= S_FILL;
                            rd_q    <= 1'b1;
                            addr_q  <= block_base(bus.miss_addr);
                        end
                    end
                end
                S_WB: begin
                    if (wb_inc && wb_last) begin
                        state_q <= S_FILL;
                        rd_q    <= 1'b1;
                        addr_q  <= base_q;
                    end else begin
                        wr_q   <= 1'b1;
                        addr_q <= word_addr(victim_q, wb_next);
                        off_q  <= word_off(wb_next);
                    end
                end
                S_FILL: begin
                    if (rcv_inc && rcv_last) begin
                        state_q <= S_TAG;
                        tag_q   <= 1'b1;
                    end else begin
                        rd_q   <= rd_more;
                        addr_q <= rd_more ? word_addr(base_q, iss_next) : '0;
                        off_q  <= word_off(rcv_next);
                    end
                end
                S_TAG: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data paths pass straight through, gated so they read zero when idle.
    assign bus.fsm_busy          = busy_q;
    assign bus.mem_read          = rd_q;
    assign bus.mem_write         = wr_q;
    assign bus.mem_addr          = addr_q;
    assign bus.mem_wdata         = wr_q ? bus.cache_rdata : '0;
    assign bus.write_data_array  = rcv_inc;
    assign bus.cache_wdata       = rcv_inc ? bus.mem_rdata : '0;
    assign bus.cache_word_offset = off_q;
    assign bus.write_tag_array   = tag_q;
    assign bus.base_addr         = base_q;

endmodule
